pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the RV64 five-stage pipeline.
- Drives the stall and flush inputs of regF/regD/regE/regM from four causes: load-use hazards, execute-stage redirects, multi-cycle ALU ops (mul/div) and data-memory wait.
- Holds a small FSM plus a watchdog counter so multi-cycle and memory waits freeze the pipe deterministically.

Parameters:
- MC_TIMEOUT, 64: max MC_WAIT cycles before the sticky timeout flag is set.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > MC_TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- decode_i_rs1  in  5  rs1 of the instruction in D.
- decode_i_rs2  in  5  rs2 of the instruction in D.
- decode_i_rs1_used  in  1  D actually reads rs1.
- decode_i_rs2_used  in  1  D actually reads rs2.
- regE_i_mem_ren  in  1  the instruction in E is a load.
- regE_i_wb_rd  in  5  destination register of E.
- regE_i_wb_reg_wen  in  1  E writes rd.
- execute_i_need_jump  in  1  E resolved a redirect (taken branch/jal/jalr mispredict).
- execute_i_mc_start  in  1  E holds a multi-cycle op.
- mc_i_done  in  1  multi-cycle unit result valid this cycle.
- mem_i_busy  in  1  data memory not ready for the access in M.
- ctrl_o_regF_stall  out  1  hold PC/regF.
- ctrl_o_regD_stall  out  1  hold regD.
- ctrl_o_regD_flush  out  1  bubble regD.
- ctrl_o_regE_stall  out  1  hold regE.
- ctrl_o_regE_flush  out  1  bubble regE.
- ctrl_o_regM_stall  out  1  hold regM.
- ctrl_o_regM_flush  out  1  bubble regM.
- ctrl_o_state  out  2  current FSM state.
- ctrl_o_mc_timeout  out  1  sticky watchdog flag.

Behaviour:
- States: RUN=0, MC_WAIT=1, MEM_WAIT=2. Encodings live in define.v.
- Reset (async, rst=1): state=RUN, wait counter=0, timeout flag=0. All stall/flush outputs read 0 while rst=1.
- Stall/flush outputs are combinational from state and current inputs. State, counter and flag update on posedge clk.
- Priority is highest first: mem_i_busy > MC_WAIT/mc start > redirect > load-use.
- Load-use hazard (lu): regE_i_mem_ren & regE_i_wb_reg_wen & rd!=0 & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)).
- RUN:
  - If mem_i_busy: stall F, D, E and M, no flushes; next state MEM_WAIT, counter=1.
  - Else if mc_start & !mc_i_done: stall F, D and E, flush M; next state MC_WAIT, counter=1.
  - Else if need_jump: flush D and E, no stalls. A load-use hazard in the same cycle is discarded.
  - Else if lu: stall F and D, flush E (exactly one bubble).
  - Else all outputs 0.
  - mc_start & mc_i_done in the same cycle: single-cycle completion, stays RUN, no stall.
- MC_WAIT:
  - Stall F, D and E, flush M. need_jump and lu are ignored.
  - Counter increments and saturates at all-ones.
  - When counter reaches MC_TIMEOUT, ctrl_o_mc_timeout is set and held until rst. The wait continues.
  - On mc_i_done: outputs drop to 0 that cycle (E advances); next state RUN, counter=0.
  - If mem_i_busy rises while in MC_WAIT, the memory freeze overlays it: M is stalled instead of flushed, state stays MC_WAIT.
- MEM_WAIT:
  - Stall F, D, E and M, no flushes.
  - On !mem_i_busy: outputs 0 that cycle; next state RUN.
  - Counter counts and saturates but never sets the timeout flag.
- A stall and a flush on the same register are never asserted together; flush is dropped.
- Reset mid-wait returns to RUN immediately and clears the counter.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - Adds outputs ctrl_o_stall_cnt[31:0] and ctrl_o_flush_cnt[31:0], both reset to 0.
  - stall_cnt increments on every cycle with ctrl_o_regF_stall=1.
  - flush_cnt increments on every cycle with ctrl_o_regD_flush=1 or ctrl_o_regE_flush=1.
  - Both wrap modulo 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- define.v holds the state encodings (ctrl_state_run/mc_wait/mem_wait) and the counter width default.
- Optional sub-module lu_detect: purely combinational hazard compare, reused by the forwarding unit.
- All sequential logic stays in pipe_hazard_ctrl.

Test Plan:
- Load-use: E = ld x5 (ren=1, wen=1, rd=5), D uses rs1=5 -> exactly one cycle of F/D stall=1 and E flush=1. With rd=0 -> no stall.
- Redirect plus load-use together: need_jump=1 and lu=1 -> D flush=1, E flush=1, no stalls, state RUN.
- Multi-cycle op: mc_start=1, done 5 cycles later -> state=1 for 5 cycles with F/D/E stall=1 and M flush=1. The done cycle has all outputs 0 and next state=0.
- Watchdog: MC_TIMEOUT=4, done never asserted -> mc_timeout rises after the 4th MC_WAIT cycle and stays 1 until rst.
- Memory wait: mem_i_busy high 3 cycles from RUN -> state=2 with all four stalls=1. The busy-low cycle has all outputs 0 and state returns to 0.
- Reset mid-wait: rst asserted in MC_WAIT -> state=0 and outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: FSM state encodings, stall/flush control bundle and the counter width default.
package pipe_hazard_ctrl_pkg;
  localparam int CNT_W_DEF = 7;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MC_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;
  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_flush;
    logic e_stall;
    logic e_flush;
    logic m_stall;
    logic m_flush;
  } ctrl_t;
  localparam ctrl_t CTRL_IDLE      = ctrl_t'(7'b0000000);
  localparam ctrl_t CTRL_FREEZE    = ctrl_t'(7'b1101010);
  localparam ctrl_t CTRL_MC_HOLD   = ctrl_t'(7'b1101001);
  localparam ctrl_t CTRL_REDIRECT  = ctrl_t'(7'b0010100);
  localparam ctrl_t CTRL_LU_BUBBLE = ctrl_t'(7'b1100100);
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and stall/flush outputs between the pipeline and the sequencer.
// Perf counter signals exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
  logic [4:0] decode_i_rs1;
  logic [4:0] decode_i_rs2;
  logic       decode_i_rs1_used;
  logic       decode_i_rs2_used;
  logic       regE_i_mem_ren;
  logic [4:0] regE_i_wb_rd;
  logic       regE_i_wb_reg_wen;
  logic       execute_i_need_jump;
  logic       execute_i_mc_start;
  logic       mc_i_done;
  logic       mem_i_busy;
  logic       ctrl_o_regF_stall;
  logic       ctrl_o_regD_stall;
  logic       ctrl_o_regD_flush;
  logic       ctrl_o_regE_stall;
  logic       ctrl_o_regE_flush;
  logic       ctrl_o_regM_stall;
  logic       ctrl_o_regM_flush;
  logic [1:0] ctrl_o_state;
  logic       ctrl_o_mc_timeout;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] ctrl_o_stall_cnt;
  logic [31:0] ctrl_o_flush_cnt;
`endif
  modport master (
    output decode_i_rs1, decode_i_rs2, decode_i_rs1_used, decode_i_rs2_used,
           regE_i_mem_ren, regE_i_wb_rd, regE_i_wb_reg_wen,
           execute_i_need_jump, execute_i_mc_start, mc_i_done, mem_i_busy,
    input  ctrl_o_regF_stall, ctrl_o_regD_stall, ctrl_o_regD_flush,
           ctrl_o_regE_stall, ctrl_o_regE_flush, ctrl_o_regM_stall, ctrl_o_regM_flush,
           ctrl_o_state, ctrl_o_mc_timeout
`ifdef PIPE_HAZARD_PERF_EN
    , input ctrl_o_stall_cnt, ctrl_o_flush_cnt
`endif
  );
  modport slave (
    input  decode_i_rs1, decode_i_rs2, decode_i_rs1_used, decode_i_rs2_used,
           regE_i_mem_ren, regE_i_wb_rd, regE_i_wb_reg_wen,
           execute_i_need_jump, execute_i_mc_start, mc_i_done, mem_i_busy,
    output ctrl_o_regF_stall, ctrl_o_regD_stall, ctrl_o_regD_flush,
           ctrl_o_regE_stall, ctrl_o_regE_flush, ctrl_o_regM_stall, ctrl_o_regM_flush,
           ctrl_o_state, ctrl_o_mc_timeout
`ifdef PIPE_HAZARD_PERF_EN
    , output ctrl_o_stall_cnt, ctrl_o_flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// pipe_hazard_ctrl_lu_detect: combinational load-use compare between the load in E and the sources of D.
module pipe_hazard_ctrl_lu_detect (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic       ren,
  input  logic       wen,
  input  logic [4:0] rd,
  output logic       lu
);
  assign lu = ren & wen & (rd != 5'd0) & ((rs1_used & (rs1 == rd)) | (rs2_used & (rs2 == rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for regF/D/E/M with multi-cycle and memory-wait watchdog FSM.
// Define PIPE_HAZARD_PERF_EN to add the stall/flush cycle counters.
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;
  logic             lu;
  logic             mc_go;
  logic             mc_end;
  ctrl_t            c;
  pipe_hazard_ctrl_lu_detect u_lu (
    .rs1      (bus.decode_i_rs1),
    .rs2      (bus.decode_i_rs2),
    .rs1_used (bus.decode_i_rs1_used),
    .rs2_used (bus.decode_i_rs2_used),
    .ren      (bus.regE_i_mem_ren),
    .wen      (bus.regE_i_wb_reg_wen),
    .rd       (bus.regE_i_wb_rd),
    .lu       (lu)
  );
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign mc_go   = bus.execute_i_mc_start & ~bus.mc_i_done;
  // a memory freeze overrides completion, so the MC wait only ends on done with memory ready
  assign mc_end  = bus.mc_i_done & ~bus.mem_i_busy;
  always_comb begin
    c = CTRL_IDLE;
    case (state)
      ST_RUN:      c = bus.mem_i_busy ? CTRL_FREEZE : mc_go ? CTRL_MC_HOLD :
                       bus.execute_i_need_jump ? CTRL_REDIRECT : lu ? CTRL_LU_BUBBLE : CTRL_IDLE;
      ST_MC_WAIT:  c = bus.mem_i_busy ? CTRL_FREEZE : bus.mc_i_done ? CTRL_IDLE : CTRL_MC_HOLD;
      ST_MEM_WAIT: c = bus.mem_i_busy ? CTRL_FREEZE : CTRL_IDLE;
      default:     c = CTRL_IDLE;
    endcase
    if (rst) c = CTRL_IDLE;
  end
  assign bus.ctrl_o_regF_stall = c.f_stall;
  assign bus.ctrl_o_regD_stall = c.d_stall;
  assign bus.ctrl_o_regD_flush = c.d_flush & ~c.d_stall;
  assign bus.ctrl_o_regE_stall = c.e_stall;
  assign bus.ctrl_o_regE_flush = c.e_flush & ~c.e_stall;
  assign bus.ctrl_o_regM_stall = c.m_stall;
  assign bus.ctrl_o_regM_flush = c.m_flush & ~c.m_stall;
  assign bus.ctrl_o_state      = state;
  assign bus.ctrl_o_mc_timeout = timeout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          state <= bus.mem_i_busy ? ST_MEM_WAIT : mc_go ? ST_MC_WAIT : ST_RUN;
          cnt   <= (bus.mem_i_busy | mc_go) ? CNT_W'(1) : '0;
        end
        ST_MC_WAIT: begin
          state <= mc_end ? ST_RUN : ST_MC_WAIT;
          cnt   <= mc_end ? '0 : cnt_inc;
          if (cnt >= CNT_W'(MC_TIMEOUT)) timeout <= 1'b1;
        end
        ST_MEM_WAIT: begin
          state <= bus.mem_i_busy ? ST_MEM_WAIT : ST_RUN;
          cnt   <= bus.mem_i_busy ? cnt_inc : '0;
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(bus.ctrl_o_regF_stall);
      flush_cnt <= flush_cnt + 32'(bus.ctrl_o_regD_flush | bus.ctrl_o_regE_flush);
    end
  end
  assign bus.ctrl_o_stall_cnt = stall_cnt;
  assign bus.ctrl_o_flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plan scenarios plus randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.MC_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  int m_mode = 0;
  int m_wait = 0;
  bit m_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic clear_in();
    bus.decode_i_rs1 = 0; bus.decode_i_rs2 = 0;
    bus.decode_i_rs1_used = 0; bus.decode_i_rs2_used = 0;
    bus.regE_i_mem_ren = 0; bus.regE_i_wb_rd = 0; bus.regE_i_wb_reg_wen = 0;
    bus.execute_i_need_jump = 0; bus.execute_i_mc_start = 0;
    bus.mc_i_done = 0; bus.mem_i_busy = 0;
  endtask

  task automatic rand_in();
    bus.decode_i_rs1 = 5'($urandom_range(0, 3));
    bus.decode_i_rs2 = 5'($urandom_range(0, 3));
    bus.decode_i_rs1_used = 1'($urandom_range(0, 1));
    bus.decode_i_rs2_used = 1'($urandom_range(0, 1));
    bus.regE_i_mem_ren = 1'($urandom_range(0, 1));
    bus.regE_i_wb_rd = 5'($urandom_range(0, 3));
    bus.regE_i_wb_reg_wen = 1'($urandom_range(0, 1));
    bus.execute_i_need_jump = ($urandom_range(0, 3) == 0);
    bus.execute_i_mc_start = ($urandom_range(0, 2) == 0);
    bus.mc_i_done = ($urandom_range(0, 3) == 0);
    bus.mem_i_busy = ($urandom_range(0, 4) == 0);
  endtask

  // one clock: check combinational outputs mid-cycle, then advance the model at the edge
  task automatic cycle();
    bit lu, busy, start, done, jump, frz, hold, redir, bub;
    logic [6:0] got, exp;
    #4;
    busy = bus.mem_i_busy; start = bus.execute_i_mc_start; done = bus.mc_i_done;
    jump = bus.execute_i_need_jump;
    lu = bus.regE_i_mem_ren && bus.regE_i_wb_reg_wen && bus.regE_i_wb_rd != 0 &&
         ((bus.decode_i_rs1_used && bus.decode_i_rs1 == bus.regE_i_wb_rd) ||
          (bus.decode_i_rs2_used && bus.decode_i_rs2 == bus.regE_i_wb_rd));
    frz   = !rst && busy;
    hold  = !rst && !busy && ((m_mode == 0 && start && !done) || (m_mode == 1 && !done));
    redir = !rst && !busy && m_mode == 0 && !(start && !done) && jump;
    bub   = !rst && !busy && m_mode == 0 && !(start && !done) && !jump && lu;
    exp = {frz | hold | bub, frz | hold | bub, redir, frz | hold, redir | bub, frz, hold};
    got = {bus.ctrl_o_regF_stall, bus.ctrl_o_regD_stall, bus.ctrl_o_regD_flush,
           bus.ctrl_o_regE_stall, bus.ctrl_o_regE_flush, bus.ctrl_o_regM_stall, bus.ctrl_o_regM_flush};
    check("ctrl", 32'(got), 32'(exp));
    check("state", 32'(bus.ctrl_o_state), 32'(rst ? 0 : m_mode));
    check("timeout", 32'(bus.ctrl_o_mc_timeout), 32'(rst ? 1'b0 : m_to));
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_wait = 0; m_to = 0;
    end else if (m_mode == 0) begin
      if (busy) begin m_mode = 2; m_wait = 1; end
      else if (start && !done) begin m_mode = 1; m_wait = 1; end
    end else if (m_mode == 1) begin
      if (m_wait >= TO) m_to = 1;
      if (done && !busy) begin m_mode = 0; m_wait = 0; end
      else m_wait = (m_wait + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_wait + 1;
    end else begin
      if (busy) m_wait = (m_wait + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_wait + 1;
      else begin m_mode = 0; m_wait = 0; end
    end
    #1;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    // load-use on rs1, then rd=0 which must not stall
    bus.regE_i_mem_ren = 1; bus.regE_i_wb_reg_wen = 1; bus.regE_i_wb_rd = 5;
    bus.decode_i_rs1 = 5; bus.decode_i_rs1_used = 1;
    #4;
    check("lu_bubble", 32'({bus.ctrl_o_regF_stall, bus.ctrl_o_regD_stall, bus.ctrl_o_regE_flush}), 32'h7);
    #(-0);
    cycle();
    bus.regE_i_wb_rd = 0; bus.decode_i_rs1 = 0;
    cycle();
    // redirect wins over load-use
    bus.regE_i_wb_rd = 5; bus.decode_i_rs1 = 5; bus.execute_i_need_jump = 1;
    cycle();
    check("jump_state", 32'(bus.ctrl_o_state), 32'd0);
    // multi-cycle op completing after five MC_WAIT cycles
    clear_in();
    bus.execute_i_mc_start = 1;
    cycle();
    repeat (5) cycle();
    check("mc_state", 32'(bus.ctrl_o_state), 32'd1);
    bus.mc_i_done = 1;
    cycle();
    check("mc_done_state", 32'(bus.ctrl_o_state), 32'd0);
    // watchdog: no done, flag rises after the fourth MC_WAIT cycle and sticks
    clear_in();
    rst = 1; cycle(); rst = 0;
    bus.execute_i_mc_start = 1;
    cycle();
    repeat (3) cycle();
    check("wd_pre", 32'(bus.ctrl_o_mc_timeout), 32'd0);
    cycle();
    check("wd_set", 32'(bus.ctrl_o_mc_timeout), 32'd1);
    repeat (6) cycle();
    bus.mc_i_done = 1;
    cycle();
    clear_in();
    cycle();
    check("wd_sticky", 32'(bus.ctrl_o_mc_timeout), 32'd1);
    // memory wait for three cycles
    bus.mem_i_busy = 1;
    repeat (3) cycle();
    check("mem_state", 32'(bus.ctrl_o_state), 32'd2);
    bus.mem_i_busy = 0;
    cycle();
    check("mem_exit", 32'(bus.ctrl_o_state), 32'd0);
    // asynchronous reset in the middle of an MC wait
    bus.execute_i_mc_start = 1;
    repeat (2) cycle();
    rst = 1;
    #1;
    check("async_state", 32'(bus.ctrl_o_state), 32'd0);
    check("async_stall", 32'(bus.ctrl_o_regF_stall), 32'd0);
    check("async_to", 32'(bus.ctrl_o_mc_timeout), 32'd0);
    cycle();
    rst = 0;
    clear_in();
    // randomized traffic with occasional resets
    repeat (3000) begin
      rand_in();
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0;
    clear_in();
    cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
